// File: rtl/retrosoc_rst_ctrl.sv
// Reset conditioner for the SoC reset pad: lock/button synchronizers, button debounce, and WAIT_LOCK/HOLD/RUN sequencer.
// Optional watchdog enabled by defining RETROSOC_RST_WDT_EN.
module retrosoc_rst_ctrl #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned LOCK_STABLE_CNT = 64,
  parameter int unsigned HOLD_CNT        = 256,
  parameter int unsigned DBNC_CNT        = 1000,
  parameter int unsigned WDT_CNT         = 2**24
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pll_locked_i,
  input  logic       btn_rst_n_i,
  input  logic       sw_rst_req_i,
  input  logic       wdt_kick_i,
  output logic       sys_rst_n_o,
  output logic       rst_done_o,
  output logic [2:0] rst_cause_o,
  output logic [1:0] state_dbg_o
);

  localparam int LOCK_W = (LOCK_STABLE_CNT > 1) ? $clog2(LOCK_STABLE_CNT) : 1;
  localparam int HOLD_W = (HOLD_CNT > 1) ? $clog2(HOLD_CNT) : 1;
  localparam int DBNC_W = (DBNC_CNT > 1) ? $clog2(DBNC_CNT) : 1;

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CNT - 1);
  localparam logic [DBNC_W-1:0] DBNC_LAST = DBNC_W'(DBNC_CNT - 1);

  localparam logic [2:0] CAUSE_POR  = 3'd0;
  localparam logic [2:0] CAUSE_LOCK = 3'd1;
  localparam logic [2:0] CAUSE_BTN  = 3'd2;
  localparam logic [2:0] CAUSE_SW   = 3'd3;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  state_e                  state_q;
  logic [SYNC_STAGES-1:0]  lock_sync_q;
  logic [SYNC_STAGES-1:0]  btn_sync_q;
  logic                    lock_s;
  logic                    btn_s;
  logic [DBNC_W-1:0]       dbnc_cnt_q;
  logic                    dbnc_q;
  logic                    press_q;
  logic [LOCK_W-1:0]       lock_cnt_q;
  logic [HOLD_W-1:0]       hold_cnt_q;
  logic                    sys_rst_n_q;
  logic                    rst_done_q;
  logic [2:0]              cause_q;
  logic                    wdt_expired;

  // Button flops reset to 1 so a POR never looks like a press.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '1;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_rst_n_i};
    end
  end

  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign btn_s  = btn_sync_q[SYNC_STAGES-1];

  // press_q pulses for one cycle right after the debounced level falls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dbnc_cnt_q <= '0;
      dbnc_q     <= 1'b1;
      press_q    <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (btn_s != dbnc_q) begin
        if (dbnc_cnt_q == DBNC_LAST) begin
          dbnc_q     <= btn_s;
          dbnc_cnt_q <= '0;
          press_q    <= dbnc_q;
        end else begin
          dbnc_cnt_q <= dbnc_cnt_q + DBNC_W'(1);
        end
      end else begin
        dbnc_cnt_q <= '0;
      end
    end
  end

`ifdef RETROSOC_RST_WDT_EN
  localparam logic [24:0] WDT_LAST = 25'(WDT_CNT - 1);

  logic [24:0] wdt_cnt_q;

  assign wdt_expired = (wdt_cnt_q == WDT_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wdt_cnt_q <= '0;
    end else if ((state_q != ST_RUN) || wdt_kick_i || wdt_expired) begin
      wdt_cnt_q <= '0;
    end else begin
      wdt_cnt_q <= wdt_cnt_q + 25'd1;
    end
  end
`else
  logic unused_wdt;

  assign wdt_expired = 1'b0;
  assign unused_wdt  = wdt_kick_i & (WDT_CNT != 0);
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_WAIT_LOCK;
      lock_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      sys_rst_n_q <= 1'b0;
      rst_done_q  <= 1'b0;
      cause_q     <= CAUSE_POR;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          sys_rst_n_q <= 1'b0;
          rst_done_q  <= 1'b0;
          if (!lock_s) begin
            lock_cnt_q <= '0;
          end else if (lock_cnt_q == LOCK_LAST) begin
            lock_cnt_q <= '0;
            hold_cnt_q <= '0;
            state_q    <= ST_HOLD;
          end else begin
            lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
          end
        end

        ST_HOLD: begin
          if (!lock_s) begin
            lock_cnt_q <= '0;
            hold_cnt_q <= '0;
            state_q    <= ST_WAIT_LOCK;
          end else if (!dbnc_q) begin
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_q  <= '0;
            sys_rst_n_q <= 1'b1;
            rst_done_q  <= 1'b1;
            state_q     <= ST_RUN;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end

        ST_RUN: begin
          // Exit priority: lock loss, button, software, watchdog.
          if (!lock_s) begin
            lock_cnt_q  <= '0;
            sys_rst_n_q <= 1'b0;
            rst_done_q  <= 1'b0;
            cause_q     <= CAUSE_LOCK;
            state_q     <= ST_WAIT_LOCK;
          end else if (press_q) begin
            hold_cnt_q  <= '0;
            sys_rst_n_q <= 1'b0;
            rst_done_q  <= 1'b0;
            cause_q     <= CAUSE_BTN;
            state_q     <= ST_HOLD;
          end else if (sw_rst_req_i) begin
            hold_cnt_q  <= '0;
            sys_rst_n_q <= 1'b0;
            rst_done_q  <= 1'b0;
            cause_q     <= CAUSE_SW;
            state_q     <= ST_HOLD;
          end else if (wdt_expired) begin
            hold_cnt_q  <= '0;
            sys_rst_n_q <= 1'b0;
            rst_done_q  <= 1'b0;
            cause_q     <= 3'd4;
            state_q     <= ST_HOLD;
          end
        end

        default: begin
          lock_cnt_q  <= '0;
          hold_cnt_q  <= '0;
          sys_rst_n_q <= 1'b0;
          rst_done_q  <= 1'b0;
          state_q     <= ST_WAIT_LOCK;
        end
      endcase
    end
  end

  assign sys_rst_n_o = sys_rst_n_q;
  assign rst_done_o  = rst_done_q;
  assign rst_cause_o = cause_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_retrosoc_rst_ctrl.sv
// Directed bench for retrosoc_rst_ctrl with small counts (LOCK=4, HOLD=8, DBNC=4, WDT=32).
// Watchdog scenarios follow RETROSOC_RST_WDT_EN.
module tb_retrosoc_rst_ctrl;

  logic       clk_i;
  logic       rst_n_i;
  logic       pll_locked_i;
  logic       btn_rst_n_i;
  logic       sw_rst_req_i;
  logic       wdt_kick_i;
  logic       sys_rst_n_o;
  logic       rst_done_o;
  logic [2:0] rst_cause_o;
  logic [1:0] state_dbg_o;

  int n_cmp;
  int n_err;

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  retrosoc_rst_ctrl #(
    .SYNC_STAGES    (2),
    .LOCK_STABLE_CNT(4),
    .HOLD_CNT       (8),
    .DBNC_CNT       (4),
    .WDT_CNT        (32)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .pll_locked_i(pll_locked_i),
    .btn_rst_n_i (btn_rst_n_i),
    .sw_rst_req_i(sw_rst_req_i),
    .wdt_kick_i  (wdt_kick_i),
    .sys_rst_n_o (sys_rst_n_o),
    .rst_done_o  (rst_done_o),
    .rst_cause_o (rst_cause_o),
    .state_dbg_o (state_dbg_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time exceeded, expected finish before 100000");
    $fatal(1, "timeout");
  end

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0; pll_locked_i = 1'b0; btn_rst_n_i = 1'b1;
    sw_rst_req_i = 1'b0; wdt_kick_i = 1'b0;
    #3;
    n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL reset_sys: got %b want 0", sys_rst_n_o); end
    n_cmp++; if (rst_done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", rst_done_o); end
    n_cmp++; if (rst_cause_o !== 3'd0) begin n_err++; $display("FAIL reset_cause: got %0d want 0", rst_cause_o); end
    n_cmp++; if (state_dbg_o !== S_WAIT) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_dbg_o); end
    tick(3);
    rst_n_i = 1'b1;
    tick(2);
    n_cmp++; if (state_dbg_o !== S_WAIT) begin n_err++; $display("FAIL reset_idle_state: got %0d want 0", state_dbg_o); end
  endtask

  task automatic test_lock_glitch;
    repeat (4) begin
      pll_locked_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick(1);
        n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL glitch_high: got %b want 0", sys_rst_n_o); end
      end
      pll_locked_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick(1);
        n_cmp++; if (state_dbg_o !== S_WAIT) begin n_err++; $display("FAIL glitch_state: got %0d want 0", state_dbg_o); end
      end
    end
  endtask

  task automatic test_por_latency;
    pll_locked_i = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick(1);
      n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL por_early edge %0d: got %b want 0", i, sys_rst_n_o); end
    end
    tick(1);
    n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL por_release: got %b want 1", sys_rst_n_o); end
    n_cmp++; if (rst_done_o !== 1'b1) begin n_err++; $display("FAIL por_done: got %b want 1", rst_done_o); end
    n_cmp++; if (rst_cause_o !== 3'd0) begin n_err++; $display("FAIL por_cause: got %0d want 0", rst_cause_o); end
    n_cmp++; if (state_dbg_o !== S_RUN) begin n_err++; $display("FAIL por_state: got %0d want 2", state_dbg_o); end
  endtask

  task automatic test_lock_loss;
    pll_locked_i = 1'b0;
    tick(2);
    n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL loss_early: got %b want 1", sys_rst_n_o); end
    tick(1);
    n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL loss_sys: got %b want 0", sys_rst_n_o); end
    n_cmp++; if (rst_done_o !== 1'b0) begin n_err++; $display("FAIL loss_done: got %b want 0", rst_done_o); end
    n_cmp++; if (rst_cause_o !== 3'd1) begin n_err++; $display("FAIL loss_cause: got %0d want 1", rst_cause_o); end
    n_cmp++; if (state_dbg_o !== S_WAIT) begin n_err++; $display("FAIL loss_state: got %0d want 0", state_dbg_o); end
    tick(4);
    pll_locked_i = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick(1);
      n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL relock_early edge %0d: got %b want 0", i, sys_rst_n_o); end
    end
    tick(1);
    n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL relock_release: got %b want 1", sys_rst_n_o); end
    n_cmp++; if (rst_cause_o !== 3'd1) begin n_err++; $display("FAIL relock_cause: got %0d want 1", rst_cause_o); end
  endtask

  task automatic test_button_bounce;
    int widths[4];
    widths = '{1, 3, 2, 3};
    foreach (widths[k]) begin
      btn_rst_n_i = 1'b0;
      for (int i = 0; i < widths[k]; i++) begin
        tick(1);
        n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL bounce_low w=%0d: got %b want 1", widths[k], sys_rst_n_o); end
      end
      btn_rst_n_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick(1);
        n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL bounce_high w=%0d: got %b want 1", widths[k], sys_rst_n_o); end
      end
    end
    tick(6);
    n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL bounce_settle: got %b want 1", sys_rst_n_o); end
    n_cmp++; if (rst_cause_o !== 3'd1) begin n_err++; $display("FAIL bounce_cause: got %0d want 1", rst_cause_o); end
  endtask

  task automatic test_button_press;
    btn_rst_n_i = 1'b0;
    tick(6);
    n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL press_early: got %b want 1", sys_rst_n_o); end
    tick(1);
    n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL press_sys: got %b want 0", sys_rst_n_o); end
    n_cmp++; if (rst_cause_o !== 3'd2) begin n_err++; $display("FAIL press_cause: got %0d want 2", rst_cause_o); end
    n_cmp++; if (state_dbg_o !== S_HOLD) begin n_err++; $display("FAIL press_state: got %0d want 1", state_dbg_o); end
    tick(3);
    btn_rst_n_i = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick(1);
      n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL press_hold edge %0d: got %b want 0", i, sys_rst_n_o); end
    end
    tick(1);
    n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL press_release: got %b want 1", sys_rst_n_o); end
  endtask

  task automatic test_sw_reset;
    sw_rst_req_i = 1'b1;
    tick(1);
    sw_rst_req_i = 1'b0;
    n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL sw_sys: got %b want 0", sys_rst_n_o); end
    n_cmp++; if (rst_cause_o !== 3'd3) begin n_err++; $display("FAIL sw_cause: got %0d want 3", rst_cause_o); end
    n_cmp++; if (state_dbg_o !== S_HOLD) begin n_err++; $display("FAIL sw_state: got %0d want 1", state_dbg_o); end
    for (int i = 1; i <= 7; i++) begin
      sw_rst_req_i = (i == 3);
      tick(1);
      n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL sw_hold edge %0d: got %b want 0", i, sys_rst_n_o); end
    end
    sw_rst_req_i = 1'b0;
    tick(1);
    n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL sw_release: got %b want 1", sys_rst_n_o); end
    n_cmp++; if (rst_cause_o !== 3'd3) begin n_err++; $display("FAIL sw_release_cause: got %0d want 3", rst_cause_o); end
  endtask

  task automatic test_button_long;
    btn_rst_n_i = 1'b0;
    tick(7);
    n_cmp++; if (rst_cause_o !== 3'd2) begin n_err++; $display("FAIL long_cause: got %0d want 2", rst_cause_o); end
    for (int i = 8; i <= 50; i++) begin
      sw_rst_req_i = (i == 20);
      tick(1);
      n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL long_stall edge %0d: got %b want 0", i, sys_rst_n_o); end
    end
    sw_rst_req_i = 1'b0;
    n_cmp++; if (rst_cause_o !== 3'd2) begin n_err++; $display("FAIL long_sw_ignored: got %0d want 2", rst_cause_o); end
    btn_rst_n_i = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      sw_rst_req_i = (i == 9);
      tick(1);
      n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL long_hold edge %0d: got %b want 0", i, sys_rst_n_o); end
    end
    sw_rst_req_i = 1'b0;
    tick(1);
    n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL long_release: got %b want 1", sys_rst_n_o); end
    n_cmp++; if (rst_cause_o !== 3'd2) begin n_err++; $display("FAIL long_release_cause: got %0d want 2", rst_cause_o); end
  endtask

  task automatic test_back_to_back;
    test_sw_reset();
    btn_rst_n_i = 1'b0;
    tick(6);
    n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL same_early: got %b want 1", sys_rst_n_o); end
    sw_rst_req_i = 1'b1;
    tick(1);
    sw_rst_req_i = 1'b0;
    n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL same_sys: got %b want 0", sys_rst_n_o); end
    n_cmp++; if (rst_cause_o !== 3'd2) begin n_err++; $display("FAIL same_cause: got %0d want 2", rst_cause_o); end
    tick(1);
    btn_rst_n_i = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick(1);
      n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL same_hold edge %0d: got %b want 0", i, sys_rst_n_o); end
    end
    tick(1);
    n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL same_release: got %b want 1", sys_rst_n_o); end
  endtask

`ifdef RETROSOC_RST_WDT_EN
  task automatic test_wdt;
    repeat (3) begin
      for (int i = 1; i <= 19; i++) begin
        tick(1);
        n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL wdt_kicked edge %0d: got %b want 1", i, sys_rst_n_o); end
      end
      wdt_kick_i = 1'b1;
      tick(1);
      wdt_kick_i = 1'b0;
    end
    for (int i = 1; i <= 31; i++) begin
      tick(1);
      n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL wdt_early edge %0d: got %b want 1", i, sys_rst_n_o); end
    end
    tick(1);
    n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL wdt_sys: got %b want 0", sys_rst_n_o); end
    n_cmp++; if (rst_cause_o !== 3'd4) begin n_err++; $display("FAIL wdt_cause: got %0d want 4", rst_cause_o); end
    tick(7);
    n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL wdt_hold: got %b want 0", sys_rst_n_o); end
    tick(1);
    n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL wdt_release: got %b want 1", sys_rst_n_o); end
  endtask
`else
  task automatic test_wdt;
    for (int i = 1; i <= 40; i++) begin
      wdt_kick_i = (i == 25);
      tick(1);
      n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL nowdt_run edge %0d: got %b want 1", i, sys_rst_n_o); end
    end
    wdt_kick_i = 1'b0;
    n_cmp++; if (rst_cause_o !== 3'd2) begin n_err++; $display("FAIL nowdt_cause: got %0d want 2", rst_cause_o); end
  endtask
`endif

  task automatic test_rst_mid_hold;
    sw_rst_req_i = 1'b1;
    tick(1);
    sw_rst_req_i = 1'b0;
    tick(3);
    n_cmp++; if (state_dbg_o !== S_HOLD) begin n_err++; $display("FAIL midhold_pre: got %0d want 1", state_dbg_o); end
    #2 rst_n_i = 1'b0;
    #1;
    n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL midhold_sys: got %b want 0", sys_rst_n_o); end
    n_cmp++; if (rst_done_o !== 1'b0) begin n_err++; $display("FAIL midhold_done: got %b want 0", rst_done_o); end
    n_cmp++; if (rst_cause_o !== 3'd0) begin n_err++; $display("FAIL midhold_cause: got %0d want 0", rst_cause_o); end
    n_cmp++; if (state_dbg_o !== S_WAIT) begin n_err++; $display("FAIL midhold_state: got %0d want 0", state_dbg_o); end
    tick(2);
    rst_n_i = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick(1);
      n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL midhold_relock edge %0d: got %b want 0", i, sys_rst_n_o); end
    end
    tick(1);
    n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL midhold_release: got %b want 1", sys_rst_n_o); end
    n_cmp++; if (rst_cause_o !== 3'd0) begin n_err++; $display("FAIL midhold_release_cause: got %0d want 0", rst_cause_o); end
  endtask

  task automatic test_rst_mid_dbnc;
    sw_rst_req_i = 1'b1;
    tick(1);
    sw_rst_req_i = 1'b0;
    tick(8);
    n_cmp++; if (rst_cause_o !== 3'd3) begin n_err++; $display("FAIL middbnc_pre_cause: got %0d want 3", rst_cause_o); end
    btn_rst_n_i = 1'b0;
    tick(4);
    n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL middbnc_pre_sys: got %b want 1", sys_rst_n_o); end
    #2 rst_n_i = 1'b0;
    #1;
    n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL middbnc_sys: got %b want 0", sys_rst_n_o); end
    n_cmp++; if (rst_done_o !== 1'b0) begin n_err++; $display("FAIL middbnc_done: got %b want 0", rst_done_o); end
    n_cmp++; if (rst_cause_o !== 3'd0) begin n_err++; $display("FAIL middbnc_cause: got %0d want 0", rst_cause_o); end
    btn_rst_n_i = 1'b1;
    tick(2);
    rst_n_i = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick(1);
      n_cmp++; if (sys_rst_n_o !== 1'b0) begin n_err++; $display("FAIL middbnc_relock edge %0d: got %b want 0", i, sys_rst_n_o); end
    end
    tick(1);
    n_cmp++; if (sys_rst_n_o !== 1'b1) begin n_err++; $display("FAIL middbnc_release: got %b want 1", sys_rst_n_o); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_lock_glitch();
    test_por_latency();
    test_lock_loss();
    test_button_bounce();
    test_button_press();
    test_sw_reset();
    test_button_long();
    test_back_to_back();
    test_wdt();
    test_rst_mid_hold();
    test_rst_mid_dbnc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/retrosoc_rst_ctrl.md
Name: retrosoc_rst_ctrl

Overview:
Reset conditioning stage directly upstream of the SoC reset pad on the FPGA build. It takes the board power-on reset, the clocking-wizard lock flag, a raw reset pushbutton and a software reset request. It produces one clean, stretched, active-low system reset for the SoC's rst_n_i_pad, plus a reset-cause code readable by firmware.

Parameters:
SYNC_STAGES, 2, flop depth of the synchronizers on pll_locked_i and btn_rst_n_i (min 2)
LOCK_STABLE_CNT, 64, consecutive cycles synchronized lock must stay high before leaving WAIT_LOCK
HOLD_CNT, 256, cycles sys_rst_n_o is held low in HOLD before release
DBNC_CNT, 1000, consecutive stable cycles needed to accept a new button level
WDT_CNT, 2**24, watchdog timeout in cycles (used only with the optional feature)

Ports:
clk_i  in  1  board clock; the block runs on this single clock
rst_n_i  in  1  power-on reset, asynchronous, active-low
pll_locked_i  in  1  clocking-wizard lock flag, asynchronous to clk_i
btn_rst_n_i  in  1  raw pushbutton, active-low, bouncy, asynchronous
sw_rst_req_i  in  1  single-cycle software reset request, synchronous to clk_i
wdt_kick_i  in  1  watchdog kick pulse, synchronous (optional feature only)
sys_rst_n_o  out  1  conditioned system reset to the SoC, registered, active-low
rst_done_o  out  1  high while in RUN
rst_cause_o  out  3  0=POR, 1=LOCK_LOSS, 2=BUTTON, 3=SW, 4=WDT

Behaviour:
- Clocking: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values: sys_rst_n_o=0, rst_done_o=0, rst_cause_o=0, state=WAIT_LOCK, all counters 0. Lock synchronizer flops are 0. Button synchronizer flops and the debounced level are 1 (released).
- Debounce: the synchronized button is compared with the debounced level. On mismatch the counter increments; on match it clears. When the counter reaches DBNC_CNT-1 with a mismatch, the debounced level flips and the counter clears. A press event is a 1->0 transition of the debounced level.
- WAIT_LOCK: sys_rst_n_o=0. The lock counter increments while synchronized lock=1 and clears on 0. At LOCK_STABLE_CNT-1 with lock=1, go to HOLD with the hold counter at 0.
- HOLD: sys_rst_n_o=0.
  - Lock drop -> WAIT_LOCK.
  - While the debounced button is pressed, the hold counter is forced to 0.
  - Otherwise the counter increments. At HOLD_CNT-1, go to RUN.
- RUN: sys_rst_n_o=1 and rst_done_o=1, both registered and updated in the same edge as the state.
  - Exit events, in priority order: lock drop -> WAIT_LOCK with cause=1; button press event -> HOLD with cause=2; sw_rst_req_i=1 -> HOLD with cause=3.
  - On exit, sys_rst_n_o falls on the same edge the state leaves RUN, i.e. one cycle after the qualifying event is visible internally.
- Latency: once pll_locked_i goes high and stays high with the button released, sys_rst_n_o rises exactly SYNC_STAGES+LOCK_STABLE_CNT+HOLD_CNT cycles after the first clk_i edge that samples it high.
- Ignored inputs:
  - sw_rst_req_i is ignored outside RUN, with no queuing.
  - A button press outside RUN does not change rst_cause_o, but does stall HOLD as above.
- rst_cause_o:
  - Written only on a RUN exit; it holds through the following HOLD/WAIT_LOCK and RUN.
  - Only rst_n_i returns it to 0.
  - A lock loss in HOLD or WAIT_LOCK does not overwrite it.
- rst_n_i asserted at any time: immediate asynchronous return to the reset values, including mid-HOLD and mid-debounce.
- Glitch rejection: a lock pulse shorter than LOCK_STABLE_CNT in WAIT_LOCK never releases reset.
- Ownership: sys_rst_n_o belongs to the clk_i domain. Synchronizing its deassertion into the system clock domain is the consumer's responsibility.

Optional Feature:
RETROSOC_RST_WDT_EN:
- Defined: a 25-bit watchdog counter runs only in RUN and clears on wdt_kick_i or on leaving RUN. Reaching WDT_CNT-1 is a RUN exit event with the lowest priority (below sw): go to HOLD, cause=4.
- Undefined: wdt_kick_i is unused, there is no counter logic, and rst_cause_o never equals 4.

Test Plan (SYNC_STAGES=2, LOCK_STABLE_CNT=4, HOLD_CNT=8, DBNC_CNT=4, WDT_CNT=32):
- POR then pll_locked_i=1 held -> sys_rst_n_o rises exactly 14 cycles after the first sampling edge; rst_done_o=1, rst_cause_o=0.
- Lock pulses of 3 cycles repeated in WAIT_LOCK -> sys_rst_n_o stays 0; a lock drop in RUN -> sys_rst_n_o=0 next edge, cause=1, relock re-releases after 14 cycles.
- Button bounces (1-3 cycle lows) in RUN -> no reset. Button held low 10 cycles -> reset asserted, cause=2. Button held 50 cycles -> reset stays low until 8 cycles after the debounced release.
- sw_rst_req_i pulse in RUN -> reset low for 8 cycles, cause=3. Pulse during HOLD -> ignored, cause unchanged. sw and button press events in the same cycle -> cause=2.
- rst_n_i asserted mid-HOLD and mid-debounce -> all outputs at reset values immediately, cause=0.
- WDT_EN defined: no kick for 32 cycles in RUN -> HOLD, cause=4. Kick every 20 cycles -> no reset.
